// File: rtl/adc_sample_reporter.sv
// adc_sample_reporter: buffers accepted ADC samples in a small FIFO and
// serializes each one as a 3-byte frame on the FPGA->AVR transmit handshake.
// Frame: byte0 = {1,000,channel}, byte1 = {0,sample[9:3]}, byte2 = {00000,sample[2:0]}.
module adc_sample_reporter #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic [15:0]                  channel_mask,
    input  logic                         new_sample,
    input  logic [9:0]                   sample,
    input  logic [3:0]                   sample_channel,
    output logic [7:0]                   tx_data,
    output logic                         new_tx_data,
    input  logic                         tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic                         overflow,
    output logic [7:0]                   drop_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

    // The registered strobe cycle is folded into the LOAD->GAP transition,
    // so no separate SEND state exists.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        GAP  = 2'd2
    } state_t;

    logic [13:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_count;
    logic          r_overflow;
    logic [7:0]    r_drop_count;

    state_t        r_state;
    logic [13:0]   r_frame;
    logic [1:0]    r_idx;
    logic [7:0]    r_tx_data;
    logic          r_new_tx_data;

    logic          w_accept;
    logic          w_full;
    logic          w_push;
    logic          w_drop;
    logic          w_pop;
    logic [13:0]   w_head;

    // Saturating 8-bit increment for the drop counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Select one byte of the frame; only byte0 carries MSB = 1.
    function automatic logic [7:0] frame_byte(input logic [13:0] f, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = {4'b1000, f[13:10]};
            2'd1:    b = {1'b0, f[9:3]};
            default: b = {5'b00000, f[2:0]};
        endcase
        return b;
    endfunction

    assign w_accept = new_sample & enable & channel_mask[sample_channel];
    assign w_full   = (r_count == FULL_LVL);
    // Fullness is judged before any same-cycle pop, so a pop never frees room for a push.
    assign w_push   = w_accept & ~w_full;
    assign w_drop   = w_accept & w_full;
    assign w_pop    = (r_state == IDLE) && (r_count != '0);
    assign w_head   = r_mem[r_rd_ptr];

    // Sample storage: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {sample_channel, sample};
        end
    end

    // FIFO pointers, occupancy and drop accounting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_drop_count <= 8'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
            if (w_drop) begin
                r_overflow   <= 1'b1;
                r_drop_count <= sat_inc8(r_drop_count);
            end
        end
    end

    // Frame register captures the FIFO head on pop.
    always_ff @(posedge clk) begin
        if (w_pop) begin
            r_frame <= w_head;
        end
    end

    // Serializer FSM: pop a frame, then send three bytes each followed by a gap cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_idx         <= 2'd0;
            r_tx_data     <= 8'd0;
            r_new_tx_data <= 1'b0;
        end else begin
            r_new_tx_data <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_idx   <= 2'd0;
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    if (!tx_busy) begin
                        r_tx_data     <= frame_byte(r_frame, r_idx);
                        r_new_tx_data <= 1'b1;
                        r_state       <= GAP;
                    end
                end
                GAP: begin
                    // Covers the one-cycle latency before tx_busy reflects the strobe.
                    if (r_idx == 2'd2) begin
                        r_state <= IDLE;
                    end else begin
                        r_idx   <= r_idx + 2'd1;
                        r_state <= LOAD;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign tx_data     = r_tx_data;
    assign new_tx_data = r_new_tx_data;
    assign fifo_level  = r_count;
    assign overflow    = r_overflow;
    assign drop_count  = r_drop_count;

endmodule

// File: tb/tb_adc_sample_reporter.sv
// Testbench for adc_sample_reporter: randomized and directed stimulus checked
// against a byte-stream reference model and handshake rules.
module tb_adc_sample_reporter;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] channel_mask = 16'h0000;
    logic        new_sample = 1'b0;
    logic [9:0]  sample = 10'd0;
    logic [3:0]  sample_channel = 4'd0;
    logic [7:0]  tx_data;
    logic        new_tx_data;
    logic        tx_busy = 1'b0;
    logic [3:0]  fifo_level;
    logic        overflow;
    logic [7:0]  drop_count;

    adc_sample_reporter #(.FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .channel_mask   (channel_mask),
        .new_sample     (new_sample),
        .sample         (sample),
        .sample_channel (sample_channel),
        .tx_data        (tx_data),
        .new_tx_data    (new_tx_data),
        .tx_busy        (tx_busy),
        .fifo_level     (fifo_level),
        .overflow       (overflow),
        .drop_count     (drop_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the bytes the link must carry, in order.
    logic [7:0] exp_q[$];

    int   cyc = 0;
    int   strobe_cnt = 0;
    int   first_strobe_cyc = 0;
    int   sample_cyc = 0;
    int   peak = 0;
    bit   prev_strobe = 1'b0;
    bit   pend_strobe = 1'b0;
    bit   force_busy = 1'b0;
    bit   rand_busy = 1'b0;
    int   busy_len = 10;
    int   bcnt = 0;
    logic [7:0] held = 8'd0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-cycle sample strobe; keep=0 marks a sample the model expects to be dropped.
    task automatic send(input logic [3:0] ch, input logic [9:0] v, input bit keep);
        new_sample     = 1'b1;
        sample         = v;
        sample_channel = ch;
        if (keep && enable && channel_mask[ch]) begin
            exp_q.push_back({4'b1000, ch});
            exp_q.push_back({1'b0, v[9:3]});
            exp_q.push_back({5'b00000, v[2:0]});
        end
        tick(1);
        new_sample = 1'b0;
    endtask

    task automatic wait_strobes(input int n, input int lim);
        int t = 0;
        while (strobe_cnt < n && t < lim) begin
            tick(1);
            t++;
        end
        check_eq("strobe_wait", strobe_cnt >= n, 1);
    endtask

    task automatic drain(input int lim);
        int t = 0;
        while (exp_q.size() > 0 && t < lim) begin
            tick(1);
            t++;
        end
        check_eq("drain_done", exp_q.size(), 0);
        tick(4);
        check_eq("level_after_drain", fifo_level, 0);
    endtask

    // Transmitter model: busy for a number of cycles starting the cycle after a strobe.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst) bcnt = 0;
            else if (pend_strobe) bcnt = rand_busy ? int'($urandom_range(1, 12)) : busy_len;
            else if (bcnt > 0) bcnt--;
            tx_busy = force_busy || (bcnt > 0);
        end
    end

    // Link monitor: handshake rules, byte order, tx_data hold.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (new_sample) sample_cyc = cyc;
            if (int'(fifo_level) > peak) peak = int'(fifo_level);
            if (new_tx_data) begin
                check_eq("strobe_while_busy", tx_busy, 0);
                check_eq("back_to_back", prev_strobe, 0);
                check_eq("byte_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check_eq("tx_byte", tx_data, exp_q.pop_front());
                if (strobe_cnt == 0) first_strobe_cyc = cyc;
                strobe_cnt++;
            end else if (!rst) begin
                check_eq("tx_data_hold", tx_data, held);
            end
            held        = tx_data;
            prev_strobe = new_tx_data;
            pend_strobe = new_tx_data;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        tick(3);
        check_eq("rst_tx_data", tx_data, 0);
        check_eq("rst_strobe", new_tx_data, 0);
        check_eq("rst_level", fifo_level, 0);
        check_eq("rst_overflow", overflow, 0);
        check_eq("rst_drops", drop_count, 0);
        rst = 1'b0;
        enable = 1'b1;
        channel_mask = 16'hFFFF;
        busy_len = 10;
        tick(2);

        // Single sample: bytes 0x83, 0x54, 0x05, first strobe three cycles later.
        strobe_cnt = 0;
        send(4'd3, 10'h2A5, 1'b1);
        wait_strobes(1, 50);
        check_eq("latency", first_strobe_cyc - sample_cyc, 3);
        drain(200);
        check_eq("single_bytes", strobe_cnt, 3);

        // Masking: only channel 0 is reported.
        channel_mask = 16'h0001;
        peak = 0;
        strobe_cnt = 0;
        send(4'd0, 10'h111, 1'b1);
        send(4'd1, 10'h222, 1'b1);
        send(4'd0, 10'h333, 1'b1);
        drain(400);
        check_eq("mask_bytes", strobe_cnt, 6);
        check_eq("mask_peak", peak <= 2, 1);

        // Random handshake, masks and enable, kept below the drop threshold.
        channel_mask = 16'hFFFF;
        rand_busy = 1'b1;
        for (int i = 0; i < 150; i++) begin
            tick($urandom_range(0, 6));
            if ($urandom_range(0, 9) == 0) channel_mask = 16'($urandom);
            enable = ($urandom_range(0, 7) != 0);
            if (exp_q.size() < 3 * (DEPTH - 1)) send(4'($urandom), 10'($urandom), 1'b1);
            else tick(1);
        end
        enable = 1'b1;
        channel_mask = 16'hFFFF;
        drain(4000);
        rand_busy = 1'b0;
        check_eq("rand_overflow", overflow, 0);
        check_eq("rand_drops", drop_count, 0);

        // Overflow: one frame stuck in the serializer, then 12 accepted samples.
        force_busy = 1'b1;
        tick(2);
        send(4'd5, 10'h3FF, 1'b1);
        tick(3);
        for (int i = 0; i < 12; i++) send(4'(i), 10'(i * 37 + 1), i < 8);
        tick(1);
        check_eq("ovf_level", fifo_level, 8);
        check_eq("ovf_flag", overflow, 1);
        check_eq("ovf_drops", drop_count, 4);
        for (int i = 0; i < 200; i++) send(4'(i), 10'(i), 1'b0);
        check_eq("drops_204", drop_count, 204);
        for (int i = 0; i < 100; i++) send(4'(i), 10'(i), 1'b0);
        check_eq("drops_sat", drop_count, 255);
        check_eq("full_level", fifo_level, 8);
        force_busy = 1'b0;
        busy_len = 2;
        drain(1500);
        check_eq("ovf_sticky", overflow, 1);
        check_eq("drops_sticky", drop_count, 255);

        // Reset mid-frame, after byte1.
        busy_len = 3;
        strobe_cnt = 0;
        send(4'd9, 10'h1FF, 1'b1);
        send(4'd10, 10'h0AA, 1'b1);
        wait_strobes(2, 100);
        #1 rst = 1'b1;
        #1;
        check_eq("midrst_strobe", new_tx_data, 0);
        check_eq("midrst_tx_data", tx_data, 0);
        check_eq("midrst_level", fifo_level, 0);
        check_eq("midrst_overflow", overflow, 0);
        check_eq("midrst_drops", drop_count, 0);
        exp_q.delete();
        tick(2);
        rst = 1'b0;
        tick(2);
        strobe_cnt = 0;
        send(4'd12, 10'h155, 1'b1);
        drain(200);
        check_eq("post_rst_bytes", strobe_cnt, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_sample_reporter.md
# adc_sample_reporter

Streams ADC samples from the AVR sampling path back to the AVR over the FPGA→AVR serial link. It accepts `new_sample`/`sample`/`sample_channel` from the AVR interface and buffers accepted samples in a small FIFO. Each sample is serialized as a 3-byte frame on the `tx_data`/`new_tx_data`/`tx_busy` transmit handshake. It sits in `mojo_top` beside the analog input path and drives the transmit inputs of the AVR interface, which are otherwise tied off.

## Interface

- `FIFO_DEPTH`, 8: sample FIFO entries; power of two, 2..64.
- `clk`  in  1: 50 MHz system clock; all state on rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `enable`  in  1: accept new samples when high.
- `channel_mask`  in  16: bit n high = report samples from channel n.
- `new_sample`  in  1: one-cycle strobe; `sample` and `sample_channel` valid.
- `sample`  in  10: ADC result.
- `sample_channel`  in  4: channel of `sample`.
- `tx_data`  out  8: byte to transmit.
- `new_tx_data`  out  1: one-cycle strobe; `tx_data` valid.
- `tx_busy`  in  1: transmitter busy; asserts the cycle after an accepted strobe.
- `fifo_level`  out  log2(FIFO_DEPTH)+1: current FIFO occupancy.
- `overflow`  out  1: sticky; set on any dropped sample.
- `drop_count`  out  8: dropped samples, saturates at 255.

## Operation

- Accept condition, per cycle: `new_sample & enable & channel_mask[sample_channel]`.
- Push: an accepted sample is written as {channel, sample} (14 bits) at that clock edge if the FIFO is not full.
- Push while full: the sample is dropped, `overflow` is set, and `drop_count` is incremented with saturation at 255. A pop in the same cycle does not free space for this push.
- A push and a pop in the same cycle are both legal when the FIFO is not full; `fifo_level` is then unchanged.
- Frame format:
  - byte0 = {1, 000, channel[3:0]}
  - byte1 = {0, sample[9:3]}
  - byte2 = {00000, sample[2:0]}
  - Only byte0 has MSB = 1, so the host resynchronizes on it.
- FSM states: IDLE, LOAD, SEND, GAP.
  - IDLE: if the FIFO is non-empty, pop the head into the frame register and set byte index = 0; go to LOAD.
  - LOAD: if `tx_busy` = 0, drive `tx_data` = byte[index] and pulse `new_tx_data`; go to GAP. Otherwise stay in LOAD.
  - GAP: one mandatory cycle that covers the one-cycle `tx_busy` assertion latency. If index = 2, go to IDLE. Otherwise increment index and go to LOAD.
  - SEND is the registered strobe cycle, folded into the LOAD→GAP transition. The implementation may merge it.
- `enable` low: no new pushes. A frame already popped completes. FIFO contents are retained and still drained.
- `channel_mask` changes apply to the next `new_sample` only; samples already queued are not filtered.
- `overflow` and `drop_count` clear only on `rst`.

## Timing

- Reset values: `tx_data` = 0, `new_tx_data` = 0, `fifo_level` = 0, `overflow` = 0, `drop_count` = 0, FSM in IDLE. Reset takes effect immediately and asynchronously, including mid-frame. A partially sent frame is abandoned and never resumed.
- Latency: `new_sample` in cycle k with the FIFO empty, the FSM idle and `tx_busy` low gives byte0 `new_tx_data` in cycle k+3 (push at edge k, pop at k+1, strobe registered at k+2).
- `new_tx_data` is never high in two consecutive cycles.
- `new_tx_data` is never asserted in a cycle where `tx_busy` = 1.
- `tx_data` is held from the strobe cycle until the next strobe.
- Minimum spacing between strobes is 2 cycles. Real spacing is set by `tx_busy`, one UART byte time.
- Bytes of one frame are always consecutive on the link. Frames are sent in FIFO order.
- `fifo_level` updates at the edge of the push or pop.

## Test plan

- Single sample: channel 3, sample 0x2A5, mask = 0xFFFF, `tx_busy` model = busy 10 cycles after each strobe → bytes 0x83, 0x54, 0x05 in order; first strobe at k+3.
- Masking: mask = 0x0001; samples on channels 0, 1, 0 → exactly two frames (channel 0), `fifo_level` peaks at ≤ 2.
- Overflow: `FIFO_DEPTH` = 8, `tx_busy` held high, 12 accepted samples → `fifo_level` = 8, `overflow` = 1, `drop_count` = 4. Release `tx_busy` → the 8 oldest frames drain in order.
- Saturation: 300 drops → `drop_count` = 255.
- Handshake: `tx_busy` random → no strobe while busy, no back-to-back strobes, byte order preserved.
- Reset mid-frame: assert `rst` after byte1 → `new_tx_data` = 0 immediately, `fifo_level` = 0. After release, a new sample produces a fresh byte0 first.
